// File: rtl/matrix_3x3_gen.sv
// rtl/matrix_3x3_gen.sv - 3x3 pixel neighbourhood generator built from two line buffers
module matrix_3x3_gen #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pix_vld,
    input  logic [DATA_W-1:0] pix_data,
    input  logic              sof,
    output logic [DATA_W-1:0] mat_p11,
    output logic [DATA_W-1:0] mat_p12,
    output logic [DATA_W-1:0] mat_p13,
    output logic [DATA_W-1:0] mat_p21,
    output logic [DATA_W-1:0] mat_p22,
    output logic [DATA_W-1:0] mat_p23,
    output logic [DATA_W-1:0] mat_p31,
    output logic [DATA_W-1:0] mat_p32,
    output logic [DATA_W-1:0] mat_p33,
    output logic              mat_en
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic [CW-1:0] col_cnt;
    logic [RW-1:0] row_cnt;
    logic [CW-1:0] eff_col;
    logic [RW-1:0] eff_row;
    logic          frame_start;

    // lb1 holds line y-1, lb2 holds line y-2; contents are never reset,
    // stale data only ever reaches the outputs while mat_en is low
    logic [DATA_W-1:0] lb1 [IMG_W];
    logic [DATA_W-1:0] lb2 [IMG_W];
    logic [DATA_W-1:0] a1;
    logic [DATA_W-1:0] a2;

    // Position of the pixel being accepted, with sof forcing (0,0)
    always_comb begin
        frame_start = pix_vld && sof;
        eff_col     = frame_start ? '0 : col_cnt;
        eff_row     = frame_start ? '0 : row_cnt;
        a1          = lb1[eff_col];
        a2          = lb2[eff_col];
    end

    // Raster counters advance only on accepted pixels and wrap at line/frame end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_cnt <= '0;
            row_cnt <= '0;
        end else if (pix_vld) begin
            if (eff_col == COL_LAST) begin
                col_cnt <= '0;
                row_cnt <= (eff_row == ROW_LAST) ? '0 : eff_row + 1'b1;
            end else begin
                col_cnt <= eff_col + 1'b1;
                row_cnt <= eff_row;
            end
        end
    end

    // Line buffers: read-before-write, current pixel into lb1, lb1's old value into lb2
    always_ff @(posedge clk) begin
        if (pix_vld) begin
            lb1[eff_col] <= pix_data;
            lb2[eff_col] <= a1;
        end
    end

    // Window shift-in of the new column and the registered window-valid flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mat_p11 <= '0;
            mat_p12 <= '0;
            mat_p13 <= '0;
            mat_p21 <= '0;
            mat_p22 <= '0;
            mat_p23 <= '0;
            mat_p31 <= '0;
            mat_p32 <= '0;
            mat_p33 <= '0;
            mat_en  <= 1'b0;
        end else begin
            mat_en <= pix_vld && (eff_row >= RW'(2)) && (eff_col >= CW'(2));
            if (pix_vld) begin
                mat_p11 <= mat_p12;
                mat_p12 <= mat_p13;
                mat_p13 <= a2;
                mat_p21 <= mat_p22;
                mat_p22 <= mat_p23;
                mat_p23 <= a1;
                mat_p31 <= mat_p32;
                mat_p32 <= mat_p33;
                mat_p33 <= pix_data;
            end
        end
    end

endmodule
